// File: rtl/hub75_fb_feeder_pkg.sv
// rtl/hub75_fb_feeder_pkg.sv - shared state encodings and width helpers for the HUB75 framebuffer feeder
package hub75_fb_feeder_pkg;

  typedef enum logic [1:0] {
    FB_ST_FILL       = 2'd0,
    FB_ST_WAIT_RDY   = 2'd1,
    FB_ST_WAIT_FRAME = 2'd2
  } fb_state_t;

  localparam logic [1:0] FB_GUARD_CYCLES = 2'd2;

  // Address width for n entries, never narrower than one bit.
  function automatic int fb_log2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hub75_fb_feeder_if.sv
// rtl/hub75_fb_feeder_if.sv - raster pixel stream with start-of-frame flag
interface hub75_fb_feeder_if #(
  parameter int BITDEPTH = 24
);
  logic [BITDEPTH-1:0] in_data;
  logic                in_sof;
  logic                in_valid;
  logic                in_ready;

  modport master (output in_data, output in_sof, output in_valid, input in_ready);
  modport slave  (input in_data, input in_sof, input in_valid, output in_ready);
endinterface

// File: rtl/hub75_fb_feeder_raster_cnt.sv
// rtl/hub75_fb_feeder_raster_cnt.sv - column/row/bank raster position counters
module hub75_fb_feeder_raster_cnt
  import hub75_fb_feeder_pkg::*;
#(
  parameter int N_BANKS     = 2,
  parameter int N_ROWS      = 32,
  parameter int N_COLS      = 64,
  parameter int LOG_N_BANKS = fb_log2w(N_BANKS),
  parameter int LOG_N_ROWS  = fb_log2w(N_ROWS),
  parameter int LOG_N_COLS  = fb_log2w(N_COLS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc_col,
  input  logic                   inc_line,
  input  logic                   clear,
  output logic [LOG_N_COLS-1:0]  col,
  output logic [LOG_N_ROWS-1:0]  row,
  output logic [LOG_N_BANKS-1:0] bank,
  output logic                   last_col,
  output logic                   last_line,
  output logic                   any_nz
);

  assign last_col  = (col == LOG_N_COLS'(N_COLS - 1));
  assign last_line = (bank == LOG_N_BANKS'(N_BANKS - 1)) && (row == LOG_N_ROWS'(N_ROWS - 1));
  assign any_nz    = |{col, row, bank};

  // clear together with inc_col restarts the line with the current pixel at column 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col  <= '0;
      row  <= '0;
      bank <= '0;
    end else if (clear) begin
      col  <= inc_col ? LOG_N_COLS'(1) : '0;
      row  <= '0;
      bank <= '0;
    end else begin
      if (inc_col)
        col <= col + LOG_N_COLS'(1);
      if (inc_line) begin
        row <= row + LOG_N_ROWS'(1);
        if (row == LOG_N_ROWS'(N_ROWS - 1))
          bank <= (bank == LOG_N_BANKS'(N_BANKS - 1)) ? '0 : bank + LOG_N_BANKS'(1);
      end
    end
  end

endmodule

// File: rtl/hub75_fb_feeder.sv
// rtl/hub75_fb_feeder.sv - writes a raster pixel stream into the HUB75 framebuffer row buffer
module hub75_fb_feeder
  import hub75_fb_feeder_pkg::*;
#(
  parameter int N_BANKS     = 2,
  parameter int N_ROWS      = 32,
  parameter int N_COLS      = 64,
  parameter int BITDEPTH    = 24,
  parameter int LOG_N_BANKS = fb_log2w(N_BANKS),
  parameter int LOG_N_ROWS  = fb_log2w(N_ROWS),
  parameter int LOG_N_COLS  = fb_log2w(N_COLS)
) (
  input  logic                   clk,
  input  logic                   rst,
  hub75_fb_feeder_if.slave       pix,
  output logic [LOG_N_BANKS-1:0] wr_bank_addr,
  output logic [LOG_N_ROWS-1:0]  wr_row_addr,
  output logic                   wr_row_store,
  input  logic                   wr_row_rdy,
  output logic                   wr_row_swap,
  output logic [BITDEPTH-1:0]    wr_data,
  output logic [LOG_N_COLS-1:0]  wr_col_addr,
  output logic                   wr_en,
  output logic                   frame_swap,
  output logic                   sof_err
);

  fb_state_t               state_q, state_d;
  logic [1:0]              guard_q, guard_d;
  logic                    run_q;
  logic                    accept;
  logic                    inc_col, inc_line, clear;
  logic                    wr_en_d, commit_d, frame_swap_d, sof_err_d;
  logic [LOG_N_COLS-1:0]   col;
  logic [LOG_N_ROWS-1:0]   row;
  logic [LOG_N_BANKS-1:0]  bank;
  logic                    last_col, last_line, any_nz;

  hub75_fb_feeder_raster_cnt #(
    .N_BANKS     (N_BANKS),
    .N_ROWS      (N_ROWS),
    .N_COLS      (N_COLS),
    .LOG_N_BANKS (LOG_N_BANKS),
    .LOG_N_ROWS  (LOG_N_ROWS),
    .LOG_N_COLS  (LOG_N_COLS)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .inc_col   (inc_col),
    .inc_line  (inc_line),
    .clear     (clear),
    .col       (col),
    .row       (row),
    .bank      (bank),
    .last_col  (last_col),
    .last_line (last_line),
    .any_nz    (any_nz)
  );

  assign pix.in_ready = run_q && (state_q == FB_ST_FILL);
  assign accept       = pix.in_valid && pix.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FB_ST_FILL;
      guard_q <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    guard_d      = guard_q;
    inc_col      = 1'b0;
    inc_line     = 1'b0;
    clear        = 1'b0;
    wr_en_d      = 1'b0;
    commit_d     = 1'b0;
    frame_swap_d = 1'b0;
    sof_err_d    = 1'b0;
    unique case (state_q)
      FB_ST_FILL: begin
        if (accept) begin
          inc_col = 1'b1;
          wr_en_d = 1'b1;
          // a misplaced start-of-frame drops the partial line and restarts the raster
          if (pix.in_sof && any_nz) begin
            clear     = 1'b1;
            sof_err_d = 1'b1;
          end else if (last_col) begin
            state_d = FB_ST_WAIT_RDY;
          end
        end
      end
      FB_ST_WAIT_RDY: begin
        if (wr_row_rdy) begin
          commit_d = 1'b1;
          if (last_line) begin
            state_d = FB_ST_WAIT_FRAME;
            guard_d = '0;
          end else begin
            inc_line = 1'b1;
            state_d  = FB_ST_FILL;
          end
        end
      end
      FB_ST_WAIT_FRAME: begin
        if (guard_q != FB_GUARD_CYCLES) begin
          guard_d = guard_q + 2'd1;
        end else if (wr_row_rdy) begin
          frame_swap_d = 1'b1;
          clear        = 1'b1;
          state_d      = FB_ST_FILL;
        end
      end
      default: state_d = FB_ST_FILL;
    endcase
  end

  // Line addresses trail the counters by a cycle, so they hold through the commit pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en        <= 1'b0;
      wr_col_addr  <= '0;
      wr_data      <= '0;
      wr_row_swap  <= 1'b0;
      wr_row_store <= 1'b0;
      frame_swap   <= 1'b0;
      sof_err      <= 1'b0;
      wr_bank_addr <= '0;
      wr_row_addr  <= '0;
    end else begin
      wr_en        <= wr_en_d;
      wr_row_swap  <= commit_d;
      wr_row_store <= commit_d;
      frame_swap   <= frame_swap_d;
      sof_err      <= sof_err_d;
      wr_bank_addr <= bank;
      wr_row_addr  <= row;
      if (accept) begin
        wr_col_addr <= clear ? '0 : col;
        wr_data     <= pix.in_data;
      end
    end
  end

endmodule

// File: tb/tb_hub75_fb_feeder.sv
// tb/tb_hub75_fb_feeder.sv - self-checking bench for hub75_fb_feeder
module tb_hub75_fb_feeder;
  localparam int NB = 2, NR = 4, NC = 8, BD = 16, TOTAL = NB * NR * NC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hub75_fb_feeder_if #(.BITDEPTH(BD)) pix ();
  logic [0:0]    wr_bank_addr;
  logic [1:0]    wr_row_addr;
  logic          wr_row_store, wr_row_swap, wr_en, frame_swap, sof_err;
  logic          wr_row_rdy = 1'b1;
  logic [BD-1:0] wr_data;
  logic [2:0]    wr_col_addr;

  hub75_fb_feeder #(.N_BANKS(NB), .N_ROWS(NR), .N_COLS(NC), .BITDEPTH(BD)) dut (
    .clk(clk), .rst(rst), .pix(pix),
    .wr_bank_addr(wr_bank_addr), .wr_row_addr(wr_row_addr), .wr_row_store(wr_row_store),
    .wr_row_rdy(wr_row_rdy), .wr_row_swap(wr_row_swap), .wr_data(wr_data),
    .wr_col_addr(wr_col_addr), .wr_en(wr_en), .frame_swap(frame_swap), .sof_err(sof_err)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Framebuffer store engine: busy for 10 cycles after every store, or forced busy.
  int rdy_cnt = 0;
  bit hold_low = 0;
  always @(posedge clk) begin
    #2;
    if (rst) rdy_cnt = 0;
    else if (wr_row_store) rdy_cnt = 10;
    else if (rdy_cnt > 0) rdy_cnt--;
    wr_row_rdy = !hold_low && (rdy_cnt == 0);
  end

  // Model: position within the frame is a single pixel count p; line = p / NC, col = p % NC.
  // phase 0 = accepting pixels, 1 = line complete awaiting store, 2 = frame complete awaiting swap.
  int cyc = 0, pcnt = 0, phase = 0, store_cyc = -100;
  int exp_ready = 0, exp_we = 0, exp_col = 0, exp_data = 0;
  int exp_commit = 0, exp_bank = 0, exp_row = 0, exp_fs = 0, exp_sof = 0;

  always @(posedge clk) begin
    cyc++;
    exp_we = 0; exp_commit = 0; exp_fs = 0; exp_sof = 0;
    if (rst) begin
      pcnt = 0; phase = 0; store_cyc = -100; exp_ready = 0;
    end else begin
      if (exp_ready != 0 && pix.in_valid) begin
        if (pix.in_sof && pcnt != 0) begin
          exp_sof = 1;
          pcnt = 0;
        end
        exp_we = 1; exp_col = pcnt % NC; exp_data = int'(pix.in_data);
        pcnt++;
        if (pcnt % NC == 0) phase = 1;
      end else if (phase == 1 && wr_row_rdy) begin
        exp_commit = 1;
        exp_bank = ((pcnt - 1) / NC) / NR;
        exp_row  = ((pcnt - 1) / NC) % NR;
        if (pcnt == TOTAL) begin phase = 2; store_cyc = cyc; end
        else phase = 0;
      end else if (phase == 2 && wr_row_rdy && (cyc - store_cyc) >= 3) begin
        exp_fs = 1; pcnt = 0; phase = 0;
      end
      exp_ready = (phase == 0) ? 1 : 0;
    end
  end

  int wl_col[$], wl_data[$], wl_cyc[$], cl_bank[$], cl_row[$], cl_cyc[$], fs_cyc[$], se_cyc[$];

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", int'({wr_en, wr_row_store, wr_row_swap, frame_swap, sof_err,
                                 wr_bank_addr, wr_row_addr, wr_col_addr, wr_data}), 0);
      chk("reset_in_ready", int'(pix.in_ready), 0);
    end else begin
      chk("in_ready", int'(pix.in_ready), exp_ready);
      chk("wr_en", int'(wr_en), exp_we);
      if (exp_we != 0) begin
        chk("wr_col_addr", int'(wr_col_addr), exp_col);
        chk("wr_data", int'(wr_data), exp_data);
      end
      chk("wr_row_swap", int'(wr_row_swap), exp_commit);
      chk("wr_row_store", int'(wr_row_store), exp_commit);
      if (exp_commit != 0) begin
        chk("wr_bank_addr", int'(wr_bank_addr), exp_bank);
        chk("wr_row_addr", int'(wr_row_addr), exp_row);
      end
      chk("frame_swap", int'(frame_swap), exp_fs);
      chk("sof_err", int'(sof_err), exp_sof);
      if (wr_en) begin wl_col.push_back(int'(wr_col_addr)); wl_data.push_back(int'(wr_data)); wl_cyc.push_back(cyc); end
      if (wr_row_store) begin cl_bank.push_back(int'(wr_bank_addr)); cl_row.push_back(int'(wr_row_addr)); cl_cyc.push_back(cyc); end
      if (frame_swap) fs_cyc.push_back(cyc);
      if (sof_err) se_cyc.push_back(cyc);
    end
  end

  task automatic clear_logs();
    wl_col.delete(); wl_data.delete(); wl_cyc.delete();
    cl_bank.delete(); cl_row.delete(); cl_cyc.delete(); fs_cyc.delete(); se_cyc.delete();
  endtask

  // Offer one pixel from posedge+1; returns the cycle number in which the handshake held.
  task automatic push(input int d, input bit s, output int acc);
    int t = 0;
    bit ok = 0;
    pix.in_data = BD'(d); pix.in_sof = s; pix.in_valid = 1'b1;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (pix.in_ready) ok = 1;
      t++;
    end
    @(posedge clk); #1;
    pix.in_valid = 1'b0; pix.in_sof = 1'b0;
    acc = cyc - 1;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_commits(input int n, input string name);
    int t = 0;
    while (cl_bank.size() < n && t < 400) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    chk(name, cl_bank.size(), n);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int acc, last_acc, sof_acc, rise;
  int gap_acc[8];

  initial begin
    pix.in_data = '0; pix.in_sof = 1'b0; pix.in_valid = 1'b0;
    wait_cycles(3);
    rst = 1'b0;

    // Line 0: 8 pixels, sof on the first
    clear_logs();
    for (int i = 0; i < 8; i++) push(i, i == 0, last_acc);
    chk("t1_ready_low_after_line", int'(pix.in_ready), 0);
    wait_commits(1, "t1_commit_count");
    for (int i = 0; i < 8; i++) begin
      chk("t1_col", wl_col[i], i);
      chk("t1_data", wl_data[i], i);
    end
    chk("t1_wr_latency", wl_cyc[7] - last_acc, 1);
    chk("t1_commit_latency", cl_cyc[0] - last_acc, 2);
    chk("t1_bank", cl_bank[0], 0);
    chk("t1_row", cl_row[0], 0);

    // Rest of the frame: lines 1..7, then one frame_swap
    for (int i = 8; i < TOTAL; i++) push(i, 0, last_acc);
    begin
      int t = 0;
      while (fs_cyc.size() == 0 && t < 300) begin @(negedge clk); t++; end
    end
    wait_cycles(5);
    chk("t2_commit_count", cl_bank.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk("t2_bank_order", cl_bank[k], k / 4);
      chk("t2_row_order", cl_row[k], k % 4);
    end
    chk("t2_fs_count", fs_cyc.size(), 1);
    chk("t2_fs_after_store", int'(fs_cyc[0] - cl_cyc[7] >= 2), 1);

    // Store engine held busy for 50 cycles after line 0
    clear_logs();
    hold_low = 1;
    for (int i = 0; i < 8; i++) push(16'h100 + i, i == 0, last_acc);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("t3_ready_held_low", int'(pix.in_ready), 0);
    end
    chk("t3_no_commit_while_busy", cl_bank.size(), 0);
    @(posedge clk); #1;
    hold_low = 0;
    rise = cyc;
    wait_commits(1, "t3_commit_count");
    chk("t3_commit_after_rise", cl_cyc[0] - rise, 1);
    chk("t3_bank", cl_bank[0], 0);
    chk("t3_row", cl_row[0], 0);

    // Misplaced sof on the 4th pixel of line 2
    clear_logs();
    for (int i = 0; i < 8; i++) push(16'h200 + i, 0, acc);
    for (int i = 0; i < 3; i++) push(16'h220 + i, 0, acc);
    push(16'h2AA, 1, sof_acc);
    for (int i = 1; i < 8; i++) push(16'h2B0 + i, 0, acc);
    wait_commits(2, "t4_commit_count");
    wait_cycles(20);
    chk("t4_commit_count_final", cl_bank.size(), 2);
    chk("t4_sof_err_count", se_cyc.size(), 1);
    chk("t4_sof_err_latency", se_cyc[0] - sof_acc, 1);
    chk("t4_sof_pixel_col", wl_col[11], 0);
    chk("t4_sof_pixel_data", wl_data[11], 16'h2AA);
    chk("t4_first_commit_row", cl_row[0], 1);
    chk("t4_restart_bank", cl_bank[1], 0);
    chk("t4_restart_row", cl_row[1], 0);

    // Reset while line 3 waits for the store engine
    clear_logs();
    for (int i = 0; i < 16; i++) push(16'h300 + i, 0, acc);
    wait_commits(2, "t5_pre_commits");
    hold_low = 1;
    for (int i = 0; i < 8; i++) push(16'h400 + i, 0, acc);
    wait_cycles(2);
    rst = 1'b1;
    #1;
    chk("t5_async_reset_outputs", int'({wr_en, wr_row_store, wr_row_swap, frame_swap, sof_err,
                                       wr_bank_addr, wr_row_addr, wr_col_addr, wr_data}), 0);
    chk("t5_async_reset_ready", int'(pix.in_ready), 0);
    wait_cycles(3);
    rst = 1'b0;
    hold_low = 0;
    wait_cycles(20);
    chk("t5_no_commit_after_reset", cl_bank.size(), 2);
    for (int i = 0; i < 8; i++) push(16'h500 + i, 0, acc);
    wait_commits(3, "t5_commit_count");
    chk("t5_bank", cl_bank[2], 0);
    chk("t5_row", cl_row[2], 0);

    // in_valid on every other cycle
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      push(16'h600 + i, 0, gap_acc[i]);
      wait_cycles(1);
    end
    wait_commits(1, "t6_commit_count");
    chk("t6_write_count", wl_col.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t6_col", wl_col[i], i);
      chk("t6_data", wl_data[i], 16'h600 + i);
      chk("t6_wr_latency", wl_cyc[i] - gap_acc[i], 1);
    end
    chk("t6_bank", cl_bank[0], 0);
    chk("t6_row", cl_row[0], 1);

    wait_cycles(5);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
